logic_cell_bundle: RTL and testbench
====================================

// Module: logic_cell_bundle
// PURPOSE
//   Bundle of three basic library cells sharing one set of input pins:
//   - a 2-input NAND,
//   - a 2:1 multiplexer with an active-low enable,
//   - a positive-edge D flip-flop with asynchronous active-low clear and preset.
//   Used as a small characterisation/teaching block for the standard-cell
//   library. Each cell is independent; they share only the iA/iB pins.
// PARAMETERS
//   WIDTH  1  bit width of iA, iB, iD, oNand, oMux, oQp, oQn (bitwise replication)
// PORTS
//   iClk   in   1      clock; the flip-flop samples on the rising edge
//   iClr   in   1      reset: asynchronous, active-low clear of the flip-flop
//   iPre   in   1      asynchronous, active-low preset of the flip-flop
//   iA     in   WIDTH  operand A (NAND input, mux input 0)
//   iB     in   WIDTH  operand B (NAND input, mux input 1)
//   iSel   in   1      mux select: 0 -> iA, 1 -> iB
//   iEnb   in   1      mux enable, active-low
//   iD     in   WIDTH  flip-flop data
//   oNand  out  WIDTH  ~(iA & iB)
//   oMux   out  WIDTH  selected operand, or 0 when disabled
//   oQp    out  WIDTH  flip-flop true output
//   oQn    out  WIDTH  flip-flop complement output
// BEHAVIOUR
//   Clocking/reset: single clock iClk; iClr is asynchronous and active-low.
//   NAND: purely combinational, zero latency.
//   - oNand = ~(iA & iB), bitwise.
//   - X/Z on an input propagates per normal Verilog semantics.
//   MUX: purely combinational, zero latency.
//   - iEnb=1: oMux = {WIDTH{1'b0}}.
//   - iEnb=0, iSel=0: oMux = iA.
//   - iEnb=0, iSel=1: oMux = iB.
//   - iSel X with iEnb=0: oMux = X.
//   FFD, asynchronous priority (highest first):
//   1. iClr=0 -> oQp=0 immediately. Clear wins when iClr and iPre are both low.
//   2. iPre=0 -> oQp=all ones immediately.
//   3. Otherwise, on posedge iClk: oQp <= iD (one-cycle latency).
//   FFD, general rules:
//   - oQn = ~oQp at all times, including during clear and preset.
//   - Reset values: oQp=0, oQn=all ones while iClr=0.
//   - Release of iClr or iPre takes effect at the next rising clock edge;
//     no output change occurs at release itself.
//   - A clock edge while iClr or iPre is held low does not change the output.
//   - Reset asserted mid-operation overrides the stored state at once.
//   - Combinational outputs (oNand, oMux) are unaffected by iClr, iPre and iClk.
// TESTING
//   1. NAND truth table, iA/iB = 00,01,10,11 -> oNand = 1,1,1,0.
//   2. Mux enable: iEnb=1, any iA/iB/iSel -> oMux=0.
//      Then iEnb=0, iA=0, iB=1: iSel=0 -> oMux=0; iSel=1 -> oMux=1.
//      Also iA=1, iB=0: iSel=0 -> oMux=1; iSel=1 -> oMux=0.
//   3. Clear: iClr=0 with iD=1, clock toggling -> oQp=0, oQn=1 throughout.
//      Release iClr=1 -> oQp=1 after the next rising edge.
//   4. Preset: iClr=1, iPre=0 -> oQp=1 immediately, no clock needed.
//      Then iClr=0 and iPre=0 together -> oQp=0 (clear priority).
//   5. Capture: iClr=iPre=1, 70 ns clock period, iD sequence 1,0,1,0,1,0,0,1,
//      each value held 3 edges -> oQp follows iD one edge later; oQn=~oQp always.
//   6. Async mid-cycle: drop iClr between clock edges while oQp=1
//      -> oQp=0 without waiting for a clock edge.

Source files
------------

// File: rtl/logic_cell_bundle_if.sv
// Pin bundle for logic_cell_bundle: shared operand pins, mux controls,
// flip-flop data and all cell outputs. Clock, clear and preset stay scalar
// ports on the module itself.
interface logic_cell_bundle_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iSel;
  logic             iEnb;
  logic [WIDTH-1:0] iD;
  logic [WIDTH-1:0] oNand;
  logic [WIDTH-1:0] oMux;
  logic [WIDTH-1:0] oQp;
  logic [WIDTH-1:0] oQn;

  // Driver side: supplies operands and controls, observes the cell outputs.
  modport master (
    output iA, iB, iSel, iEnb, iD,
    input  oNand, oMux, oQp, oQn
  );

  // Cell side: consumes operands and controls, produces the cell outputs.
  modport slave (
    input  iA, iB, iSel, iEnb, iD,
    output oNand, oMux, oQp, oQn
  );
endinterface

// File: rtl/logic_cell_bundle.sv
// logic_cell_bundle: three independent library cells sharing the iA/iB pins.
//   - 2-input NAND (combinational)
//   - 2:1 mux with active-low enable (combinational)
//   - rising-edge D flip-flop with asynchronous active-low clear and preset;
//     clear dominates preset, and oQn is always the complement of oQp.
// All cells are replicated bitwise over WIDTH.
module logic_cell_bundle #(
  parameter int WIDTH = 1
) (
  input logic                 iClk,
  input logic                 iClr,
  input logic                 iPre,
  logic_cell_bundle_if.slave  bus
);

  logic [WIDTH-1:0] nand_s;
  logic [WIDTH-1:0] mux_s;
  logic [WIDTH-1:0] qp_r;

  // NAND cell: bitwise complement of the AND of both operands.
  always_comb begin
    nand_s = ~(bus.iA & bus.iB);
  end

  // Mux cell: disabled forces zero; an unknown select yields unknown data.
  always_comb begin
    mux_s = {WIDTH{1'b0}};
    if (bus.iEnb) begin
      mux_s = {WIDTH{1'b0}};
    end else begin
      case (bus.iSel)
        1'b0:    mux_s = bus.iA;
        1'b1:    mux_s = bus.iB;
        default: mux_s = {WIDTH{1'bx}};
      endcase
    end
  end

  // Flip-flop storage: clear beats preset, both act without a clock edge;
  // releasing either only matters at the following rising edge.
  always_ff @(posedge iClk or negedge iClr or negedge iPre) begin
    if (!iClr) begin
      qp_r <= {WIDTH{1'b0}};
    end else if (!iPre) begin
      qp_r <= {WIDTH{1'b1}};
    end else begin
      qp_r <= bus.iD;
    end
  end

  assign bus.oNand = nand_s;
  assign bus.oMux  = mux_s;
  assign bus.oQp   = qp_r;
  assign bus.oQn   = ~qp_r;

endmodule

// File: tb/tb_logic_cell_bundle.sv
// Directed bench for logic_cell_bundle. Stimulus changes inputs shortly after
// a rising edge and queues the hand-computed expectation; a monitor on the
// falling edge drains the queue and compares against the DUT outputs.
module tb_logic_cell_bundle;

  localparam int W = 1;

  typedef struct {
    string        name;
    bit [2:0]     mask;    // [2] nand, [1] mux, [0] qp/qn
    logic [W-1:0] exp_nand;
    logic [W-1:0] exp_mux;
    logic [W-1:0] exp_qp;
  } exp_t;

  logic iClk;
  logic iClr;
  logic iPre;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];
  exp_t cur;

  logic_cell_bundle_if #(.WIDTH(W)) bus ();

  logic_cell_bundle #(.WIDTH(W)) dut (
    .iClk (iClk),
    .iClr (iClr),
    .iPre (iPre),
    .bus  (bus)
  );

  // 70 ns clock period.
  initial begin
    iClk = 1'b0;
    forever #35 iClk = ~iClk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input string nm, input bit [2:0] m,
                      input logic [W-1:0] n, input logic [W-1:0] mx, input logic [W-1:0] q);
    exp_t e;
    e.name     = nm;
    e.mask     = m;
    e.exp_nand = n;
    e.exp_mux  = mx;
    e.exp_qp   = q;
    sb_q.push_back(e);
  endtask

  task automatic step(input int dly);
    @(posedge iClk);
    #(dly);
  endtask

  // Monitor: every falling edge, check all pending expectations.
  always @(negedge iClk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      if (cur.mask[2]) chk({cur.name, ".nand"}, bus.oNand, cur.exp_nand);
      if (cur.mask[1]) chk({cur.name, ".mux"},  bus.oMux,  cur.exp_mux);
      if (cur.mask[0]) begin
        chk({cur.name, ".qp"}, bus.oQp, cur.exp_qp);
        chk({cur.name, ".qn"}, bus.oQn, ~cur.exp_qp);
      end
    end
  end

  // Directed vectors.
  logic [W-1:0] na_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] nb_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] ne_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic [W-1:0] ma_t [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] mb_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic         ms_t [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic         me_t [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] mo_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [W-1:0] dseq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [W-1:0] prev;
    n_cmp    = 0;
    n_bad    = 0;
    iClr     = 1'b0;
    iPre     = 1'b1;
    bus.iA   = 1'b0;
    bus.iB   = 1'b0;
    bus.iSel = 1'b0;
    bus.iEnb = 1'b1;
    bus.iD   = 1'b0;
    repeat (2) @(posedge iClk);

    // Reset state.
    step(1);
    push("reset", 3'b111, 1'b1, 1'b0, 1'b0);

    // NAND truth table (clear still held: combinational cells unaffected).
    for (int i = 0; i < 4; i++) begin
      step(1);
      bus.iA = na_t[i];
      bus.iB = nb_t[i];
      push($sformatf("nand%0d", i), 3'b101, ne_t[i], 1'b0, 1'b0);
    end

    // Mux enable / select.
    for (int i = 0; i < 7; i++) begin
      step(1);
      bus.iA   = ma_t[i];
      bus.iB   = mb_t[i];
      bus.iSel = ms_t[i];
      bus.iEnb = me_t[i];
      push($sformatf("mux%0d", i), 3'b010, 1'b0, mo_t[i], 1'b0);
    end

    // Clear held with iD=1 and clock running.
    step(1);
    bus.iD = 1'b1;
    push("clr_hold0", 3'b001, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++) begin
      step(1);
      push($sformatf("clr_hold%0d", i), 3'b001, 1'b0, 1'b0, 1'b0);
    end
    step(1);
    iClr = 1'b1;
    push("clr_release", 3'b001, 1'b0, 1'b0, 1'b0);
    step(1);
    push("clr_first_edge", 3'b001, 1'b0, 1'b0, 1'b1);

    // Preset, then clear priority over preset.
    step(1);
    bus.iD = 1'b0;
    push("cap_one", 3'b001, 1'b0, 1'b0, 1'b1);
    step(1);
    push("cap_zero", 3'b001, 1'b0, 1'b0, 1'b0);
    step(1);
    iPre = 1'b0;
    push("preset_async", 3'b001, 1'b0, 1'b0, 1'b1);
    step(1);
    push("preset_hold", 3'b001, 1'b0, 1'b0, 1'b1);
    step(1);
    iClr = 1'b0;
    push("clr_over_pre", 3'b001, 1'b0, 1'b0, 1'b0);
    step(1);
    iClr = 1'b1;
    iPre = 1'b1;
    push("release_both", 3'b001, 1'b0, 1'b0, 1'b0);
    step(1);
    push("post_release", 3'b001, 1'b0, 1'b0, 1'b0);

    // Capture sequence, each value held for three edges.
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        step(1);
        if (k == 0) bus.iD = dseq[i];
        push($sformatf("cap%0d_%0d", i, k), 3'b001, 1'b0, 1'b0,
             (k == 0) ? prev : dseq[i]);
      end
      prev = dseq[i];
    end

    // Clear dropped between edges while oQp=1.
    step(1);
    push("pre_drop", 3'b001, 1'b0, 1'b0, 1'b1);
    step(10);
    iClr = 1'b0;
    push("mid_cycle_clr", 3'b001, 1'b0, 1'b0, 1'b0);
    step(1);
    iClr = 1'b1;
    push("mid_release", 3'b001, 1'b0, 1'b0, 1'b0);
    step(1);
    push("mid_recapture", 3'b001, 1'b0, 1'b0, 1'b1);

    @(negedge iClk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
